// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin packet arbiter that merges NUM_REQ valid/ready streams
// into one registered output stage, holding each grant until the packet's last beat.
module stream_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_WIDTH = 32,
   localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_last,
   output logic [SRC_W-1:0]              out_src
);
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t state, state_nxt;
   logic [SRC_W-1:0] rr_ptr, rr_ptr_nxt, lock_idx, lock_idx_nxt, grant;
   logic gnt_vld, load_en, accept, g_valid, g_last;
   logic [DATA_WIDTH-1:0] g_data;

   assign load_en = !out_valid || out_ready;

   always_comb begin
      grant = lock_idx;
      gnt_vld = (state == LOCKED);
      // lowest valid index is the wrap-around fallback; lowest valid at or above rr_ptr wins
      if (state == IDLE) begin
         for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_valid[i]) begin
               grant = SRC_W'(i);
               gnt_vld = 1'b1;
            end
         for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_valid[i] && SRC_W'(i) >= rr_ptr) grant = SRC_W'(i);
      end
      g_valid = 1'b0;
      g_last = 1'b0;
      g_data = '0;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (gnt_vld && grant == SRC_W'(i)) begin
            g_valid = req_valid[i];
            g_last = req_last[i];
            g_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            req_ready[i] = load_en && rst_n;
         end
      accept = g_valid && load_en;
      state_nxt = state;
      rr_ptr_nxt = rr_ptr;
      lock_idx_nxt = lock_idx;
      if (accept) begin
         state_nxt = g_last ? IDLE : LOCKED;
         lock_idx_nxt = g_last ? lock_idx : grant;
         rr_ptr_nxt = !g_last ? rr_ptr : (grant == SRC_W'(NUM_REQ - 1)) ? '0 : grant + SRC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         rr_ptr <= '0;
         lock_idx <= '0;
      end else begin
         state <= state_nxt;
         rr_ptr <= rr_ptr_nxt;
         lock_idx <= lock_idx_nxt;
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data <= '0;
         out_last <= 1'b0;
         out_src <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data <= g_data;
         out_last <= g_last;
         out_src <= grant;
      end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: random multi-requester packet traffic against a queue-based
// arbitration model, with a decoupled output monitor, plus a 3-requester wrap check.
module tb_stream_rr_arbiter;
   localparam int N = 4, DW = 32;
   logic clk = 0, rst_n = 0;
   logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
   logic [N*DW-1:0] req_data = '0;
   logic out_valid, out_last, out_ready = 0;
   logic [DW-1:0] out_data;
   logic [1:0] out_src;
   logic [2:0] r3_valid = '0, r3_last = '0, r3_ready;
   logic [23:0] r3_data = '0;
   logic o3_valid, o3_last, o3_ready = 0;
   logic [7:0] o3_data;
   logic [1:0] o3_src;
   typedef struct packed {logic [DW-1:0] data; logic last; logic [1:0] src;} beat_t;
   beat_t sb[$];
   int checks = 0, errors = 0;
   int owner = -1, ptr = 0, acc_idx = -1;
   bit m_ov = 0, stop = 0;
   int rem[N];
   int p_valid, p_ready, max_len;
   int exp3[5] = '{2, 0, 2, 0, 2};

   always #5 clk = ~clk;

   stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_last(req_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .out_src(out_src));

   stream_rr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8)) u3 (
      .clk(clk), .rst_n(rst_n), .req_valid(r3_valid), .req_ready(r3_ready),
      .req_data(r3_data), .req_last(r3_last), .out_valid(o3_valid), .out_ready(o3_ready),
      .out_data(o3_data), .out_last(o3_last), .out_src(o3_src));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk)
      if (rst_n && out_valid && out_ready) begin
         beat_t e;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_beat: got %0h src %0d expected no beat", out_data, out_src);
         end else begin
            e = sb.pop_front();
            check("out_beat", {out_data, out_last, out_src}, e);
         end
      end

   task automatic observe();
      @(posedge clk);
      #1;
      check("out_valid", out_valid, m_ov);
      if (acc_idx >= 0) begin
         req_valid[acc_idx] = 0;
         rem[acc_idx]--;
         acc_idx = -1;
      end
      for (int i = 0; i < N; i++)
         if (!req_valid[i] && (rem[i] > 0 || !stop) && $urandom_range(99) < p_valid) begin
            if (rem[i] == 0) rem[i] = $urandom_range(max_len, 1);
            req_valid[i] = 1;
            req_data[i*DW +: DW] = $urandom;
            req_last[i] = (rem[i] == 1);
         end
      out_ready = $urandom_range(99) < p_ready;
   endtask

   // predicts the beat taken at the coming edge from owner/pointer rules
   task automatic predict();
      int g;
      logic [N-1:0] er;
      #1;
      g = owner;
      for (int k = 0; k < N && g < 0; k++)
         if (req_valid[(ptr + k) % N]) g = (ptr + k) % N;
      er = '0;
      if (g >= 0) er[g] = !m_ov || out_ready;
      check("req_ready", req_ready, er);
      if (g >= 0 && req_valid[g] && er[g]) begin
         sb.push_back({req_data[g*DW +: DW], req_last[g], 2'(g)});
         m_ov = 1;
         acc_idx = g;
         if (req_last[g]) begin
            owner = -1;
            ptr = (g + 1) % N;
         end else owner = g;
      end else if (out_ready) m_ov = 0;
   endtask

   task automatic run(input int n, input int pv, input int pr, input int ml);
      p_valid = pv;
      p_ready = pr;
      max_len = ml;
      repeat (n) begin
         observe();
         predict();
      end
   endtask

   task automatic do_reset();
      #2;
      rst_n = 0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_req_ready", req_ready, 0);
      owner = -1;
      ptr = 0;
      m_ov = 0;
      acc_idx = -1;
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1;
      predict();
      check("rst_first_grant", req_ready, 4'b0001);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("init_out_valid", out_valid, 0);
      check("init_out_data", out_data, 0);
      check("init_out_src", out_src, 0);
      rst_n = 1;
      predict();
      run(60, 100, 100, 1);
      do_reset();
      run(40, 100, 100, 1);
      run(400, 60, 70, 4);
      run(300, 80, 25, 3);
      run(200, 90, 90, 5);
      stop = 1;
      p_valid = 100;
      p_ready = 100;
      for (int c = 0; c < 300 && (req_valid != 0 || sb.size() != 0); c++) begin
         observe();
         predict();
      end
      check("drain_sb_empty", sb.size(), 0);
      check("drain_req_valid", req_valid, 0);
      r3_data = {8'hC2, 8'hC1, 8'hC0};
      r3_last = 3'b111;
      o3_ready = 1;
      @(posedge clk);
      #1;
      r3_valid = 3'b100;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) r3_valid = 3'b101;
         check("n3_valid", o3_valid, 1);
         check("n3_src", o3_src, exp3[i]);
         check("n3_data", o3_data, 8'hC0 + exp3[i]);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
